// File: rtl/hbm_init_sequencer_if.sv
// Bundles the sequencer's control inputs and its reset/status outputs.
// The master modport is the sequencer itself; the slave modport is the surrounding system.
interface hbm_init_sequencer_if;
   logic       trigger;
   logic       cal_done;
   logic       mig_rstn;
   logic       rstn;
   logic       done;
   logic [1:0] err;
   logic [2:0] state;

   modport master (
      input  trigger,
      input  cal_done,
      output mig_rstn,
      output rstn,
      output done,
      output err,
      output state
   );

   modport slave (
      output trigger,
      output cal_done,
      input  mig_rstn,
      input  rstn,
      input  done,
      input  err,
      input  state
   );
endinterface

// File: rtl/hbm_init_sequencer.sv
// Power-up / software-restart sequencer: releases the HBM controller reset, waits for calibration,
// then releases user logic; a trigger toggle restarts the sequence from any state.
module hbm_init_sequencer #(
   parameter int unsigned MC_RST_CYCLES  = 1000,
   parameter int unsigned USR_RST_CYCLES = 64,
   parameter int unsigned CAL_TIMEOUT    = 1048576,
   parameter int unsigned CNT_W          = 21
) (
   input  logic                 clk,
   input  logic                 rst,
   hbm_init_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      ST_MC_RST   = 3'd0,
      ST_WAIT_CAL = 3'd1,
      ST_USR_RST  = 3'd2,
      ST_RUN      = 3'd3,
      ST_FAIL     = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] MC_LAST  = CNT_W'(MC_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] USR_LAST = CNT_W'(USR_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] CAL_LAST = CNT_W'(CAL_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_LOST    = 2'b10;

   logic             trig_s1_r, trig_s2_r, trig_s3_r;
   logic             cal_s1_r, cal_s2_r;
   logic             trig_evt_s, cal_done_s;
   state_t           state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic [1:0]       err_r, err_nxt_s;
   logic             mig_rstn_s, rstn_s, done_s;

   assign trig_evt_s = trig_s2_r ^ trig_s3_r;
   assign cal_done_s = cal_s2_r;

   // Synchronise the asynchronous inputs; the third trigger flop gives a toggle detector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trig_s1_r <= 1'b0;
         trig_s2_r <= 1'b0;
         trig_s3_r <= 1'b0;
         cal_s1_r  <= 1'b0;
         cal_s2_r  <= 1'b0;
      end else begin
         trig_s1_r <= bus.trigger;
         trig_s2_r <= trig_s1_r;
         trig_s3_r <= trig_s2_r;
         cal_s1_r  <= bus.cal_done;
         cal_s2_r  <= cal_s1_r;
      end
   end

   // State, duration counter and sticky error code.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_MC_RST;
         cnt_r   <= CNT_ZERO;
         err_r   <= ERR_NONE;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         err_r   <= err_nxt_s;
      end
   end

   // Next-state logic: a restart event overrides every other transition.
   always_comb begin
      state_nxt_s = state_r;
      err_nxt_s   = err_r;
      if (trig_evt_s) begin
         state_nxt_s = ST_MC_RST;
         err_nxt_s   = ERR_NONE;
      end else begin
         case (state_r)
            ST_MC_RST: begin
               if (cnt_r == MC_LAST) state_nxt_s = ST_WAIT_CAL;
               else                  state_nxt_s = ST_MC_RST;
            end
            ST_WAIT_CAL: begin
               // Calibration completing wins over a coincident timeout.
               if (cal_done_s) begin
                  state_nxt_s = ST_USR_RST;
               end else if (cnt_r == CAL_LAST) begin
                  state_nxt_s = ST_FAIL;
                  err_nxt_s   = ERR_TIMEOUT;
               end else begin
                  state_nxt_s = ST_WAIT_CAL;
               end
            end
            ST_USR_RST: begin
               if (!cal_done_s) begin
                  state_nxt_s = ST_FAIL;
                  err_nxt_s   = ERR_LOST;
               end else if (cnt_r == USR_LAST) begin
                  state_nxt_s = ST_RUN;
               end else begin
                  state_nxt_s = ST_USR_RST;
               end
            end
            ST_RUN: begin
               if (!cal_done_s) begin
                  state_nxt_s = ST_FAIL;
                  err_nxt_s   = ERR_LOST;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
            ST_FAIL: state_nxt_s = ST_FAIL;
            default: begin
               state_nxt_s = ST_MC_RST;
               err_nxt_s   = ERR_NONE;
            end
         endcase
      end
   end

   // Counter clears on every state entry (including restart into MC_RST) and idles in RUN/FAIL.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (trig_evt_s || (state_nxt_s != state_r)) begin
         cnt_nxt_s = CNT_ZERO;
      end else if ((state_r == ST_MC_RST) || (state_r == ST_WAIT_CAL) || (state_r == ST_USR_RST)) begin
         cnt_nxt_s = cnt_r + CNT_ONE;
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Output decode from the state register only.
   always_comb begin
      mig_rstn_s = 1'b0;
      rstn_s     = 1'b0;
      done_s     = 1'b0;
      case (state_r)
         ST_WAIT_CAL: mig_rstn_s = 1'b1;
         ST_USR_RST:  mig_rstn_s = 1'b1;
         ST_RUN: begin
            mig_rstn_s = 1'b1;
            rstn_s     = 1'b1;
            done_s     = 1'b1;
         end
         default: begin
            mig_rstn_s = 1'b0;
            rstn_s     = 1'b0;
            done_s     = 1'b0;
         end
      endcase
   end

   assign bus.mig_rstn = mig_rstn_s;
   assign bus.rstn     = rstn_s;
   assign bus.done     = done_s;
   assign bus.err      = err_r;
   assign bus.state    = state_r;

endmodule
